pll_reset_seq: RTL and testbench
================================

// Module: pll_reset_seq
// PURPOSE
//  Consumes the rPLL LOCK flag (27 MHz in -> 270 MHz out) and sequences the design's resets.
//  Runs on the 27 MHz board clock: synchronises LOCK, qualifies it for a stable window,
//  then releases core, DSP and video resets in staggered order.
//  Re-asserts all resets on loss of lock. Pulses the PLL RESET pin if lock is not acquired in time.
//  Reset outputs feed per-domain 2-FF reset synchronisers in each destination clock domain.
// PARAMETERS
//  SYNC_STAGES      2       flops in LOCK synchroniser (>=2)
//  PLL_RST_CYCLES   32      clk cycles pll_reset_o held high per PLL reset pulse
//  LOCK_STABLE      2700    consecutive synced-lock cycles required (100 us @27 MHz)
//  LOCK_TIMEOUT     270000  cycles in WAIT_LOCK before re-pulsing PLL reset (10 ms)
//  STAGGER          16      cycles between successive reset releases
//  CNT_W            8       width of event counters (saturating)
// PORTS
//  clk              in   1      27 MHz board clock (rPLL CLKIN source)
//  rst              in   1      synchronous active-high reset
//  pll_lock_i       in   1      rPLL LOCK, asynchronous to clk
//  pll_reset_o      out  1      drives rPLL RESET, active-high
//  rst_core_o       out  1      core reset, active-high
//  rst_dsp_o        out  1      DSP datapath reset, active-high
//  rst_video_o      out  1      video/TMDS reset, active-high
//  sys_ready_o      out  1      1 = all resets released and lock held
//  lock_loss_cnt_o  out  CNT_W  count of RUN->lock-lost events, saturating
//  timeout_cnt_o    out  CNT_W  count of WAIT_LOCK timeouts, saturating
//  state_o          out  3      current FSM state encoding, debug only
// BEHAVIOUR
//  Clock and reset:
//   - Single clock domain; rst is synchronous, active-high. Reset wins over every other event.
//   - While rst=1 and on the first cycle after: pll_reset_o=0, rst_core/dsp/video_o=1,
//     sys_ready_o=0, both counters=0, synchroniser flops=0, state=WAIT_LOCK (state_o=1).
//  Lock synchronisation:
//   - lock_s = pll_lock_i delayed through SYNC_STAGES flops.
//   - All FSM decisions use lock_s only.
//  State encoding:
//   - PLL_RST=0, WAIT_LOCK=1, STABLE=2, REL_CORE=3, REL_DSP=4, REL_VIDEO=5, RUN=6.
//   - One shared down-counter cnt (width sized for max(LOCK_TIMEOUT, LOCK_STABLE)).
//   - cnt is reloaded on every state entry.
//  PLL_RST:
//   - pll_reset_o=1 for exactly PLL_RST_CYCLES cycles, then -> WAIT_LOCK.
//   - All domain resets remain 1.
//  WAIT_LOCK:
//   - lock_s=1 -> STABLE.
//   - cnt expires -> PLL_RST, timeout_cnt_o+1.
//   - lock_s=1 in the expiry cycle: lock takes priority -> STABLE, no count.
//  STABLE:
//   - Needs LOCK_STABLE consecutive lock_s=1 cycles, counted from entry, then -> REL_CORE.
//   - Any lock_s=0 -> WAIT_LOCK with a fresh timeout.
//  REL_CORE:
//   - rst_core_o deasserts on the entry cycle.
//   - After STAGGER cycles -> REL_DSP, where rst_dsp_o deasserts on entry.
//   - After STAGGER more cycles -> REL_VIDEO, where rst_video_o deasserts on entry.
//   - After STAGGER more cycles -> RUN; sys_ready_o=1 from RUN entry.
//  Loss of lock:
//   - lock_s=0 in any of REL_CORE..RUN: same cycle as detection the FSM moves to WAIT_LOCK.
//   - All three resets and sys_ready_o are registered to 1/0 on that edge.
//   - lock_loss_cnt_o+1 only if the lost state was RUN.
//   - Lock glitches shorter than the synchroniser are not required to be detected.
//  Output rules:
//   - All outputs are registered; no combinational path from pll_lock_i.
//   - Counters saturate at 2^CNT_W-1 and never wrap.
//   - Release order is always core, then dsp, then video.
//   - Assertion of all three is simultaneous.
//   - A reset output never deasserts while the reset released before it is asserted.
// TESTING (bench parameters: LOCK_STABLE=8, LOCK_TIMEOUT=40, STAGGER=4, PLL_RST_CYCLES=3)
//  1 Power-up:
//    - rst 5 cycles, lock rises at cycle 10.
//    - rst_core_o falls at 10+2+8 (+-1); dsp 4 cycles later; video 4 later.
//    - sys_ready_o=1 at video+4; pll_reset_o stays 0.
//  2 Never locks:
//    - lock held 0.
//    - After 40 cycles pll_reset_o pulses high for 3 cycles.
//    - timeout_cnt_o=1, then 2 after the next timeout.
//  3 Chatter in STABLE:
//    - lock high 5 cycles, low 1, high.
//    - Stable window restarts; release delayed by the full 8 cycles after the re-rise.
//  4 Loss in RUN:
//    - Drop lock at steady state.
//    - Within SYNC_STAGES+1 cycles all resets=1 and sys_ready_o=0; lock_loss_cnt_o=1.
//    - Relock repeats the scenario-1 sequence.
//  5 Loss during REL_DSP:
//    - All resets reasserted; lock_loss_cnt_o unchanged.
//  6 Saturation and mid-run reset:
//    - CNT_W=2 with 5 RUN losses -> lock_loss_cnt_o=3.
//    - rst asserted mid-RUN -> the cycle-after values listed under Clock and reset.

Source files
------------

// File: rtl/pll_reset_seq.sv
// Purpose : sequences PLL reset and staggered core/DSP/video resets from the rPLL LOCK flag.
// Latency : LOCK seen SYNC_STAGES+1 cycles after it changes; releases LOCK_STABLE then STAGGER apart.
// Flow    : no handshake; loss of lock re-asserts every reset on the next clk edge.
//
// Ports:
//   clk              27 MHz board clock (also the rPLL reference)
//   rst              synchronous active-high reset
//   pll_lock_i       rPLL LOCK, asynchronous to clk
//   pll_reset_o      rPLL RESET pin, high while a reset pulse is being issued
//   rst_core_o       core-domain reset, active-high
//   rst_dsp_o        DSP-domain reset, active-high
//   rst_video_o      video/TMDS-domain reset, active-high
//   sys_ready_o      all resets released and lock still held
//   lock_loss_cnt_o  saturating count of lock losses while fully running
//   timeout_cnt_o    saturating count of lock-acquisition timeouts
//   state_o          FSM state code, debug only
//
// Every output is a flop; nothing combinational reaches the ports from pll_lock_i.
// Reset outputs are meant to be re-synchronised in each destination domain.

module pll_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 32,
    parameter int LOCK_STABLE    = 2700,
    parameter int LOCK_TIMEOUT   = 270000,
    parameter int STAGGER        = 16,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock_i,
    output logic             pll_reset_o,
    output logic             rst_core_o,
    output logic             rst_dsp_o,
    output logic             rst_video_o,
    output logic             sys_ready_o,
    output logic [CNT_W-1:0] lock_loss_cnt_o,
    output logic [CNT_W-1:0] timeout_cnt_o,
    output logic [2:0]       state_o
);

    // The shared down-counter is loaded with (duration - 1), so it only has to
    // hold the largest duration minus one.
    localparam int MAX_AB = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int MAX_CD = (PLL_RST_CYCLES > STAGGER) ? PLL_RST_CYCLES : STAGGER;
    localparam int MAX_LD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW     = (MAX_LD > 2) ? $clog2(MAX_LD) : 1;

    localparam logic [TW-1:0]    LD_PLL     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0]    LD_TIMEOUT = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    LD_STABLE  = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0]    LD_STAGGER = TW'(STAGGER - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_REL_CORE  = 3'd3,
        S_REL_DSP   = 3'd4,
        S_REL_VIDEO = 3'd5,
        S_RUN       = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_s;
    state_t                 r_state;
    logic [TW-1:0]          r_cnt;
    logic                   w_cnt_zero;
    logic                   w_released;

    logic                   r_pll_reset;
    logic                   r_rst_core;
    logic                   r_rst_dsp;
    logic                   r_rst_video;
    logic                   r_sys_ready;
    logic [CNT_W-1:0]       r_loss_cnt;
    logic [CNT_W-1:0]       r_timeout_cnt;

    // LOCK synchroniser: plain shift chain, oldest sample drives the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock_i};
        end
    end

    assign w_lock_s   = r_sync[SYNC_STAGES-1];
    assign w_cnt_zero = (r_cnt == '0);
    // At least one domain reset has been released in these states, so a lock
    // drop must pull everything back into reset.
    assign w_released = (r_state == S_REL_CORE)  || (r_state == S_REL_DSP) ||
                        (r_state == S_REL_VIDEO) || (r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_WAIT_LOCK;
            r_cnt         <= LD_TIMEOUT;
            r_pll_reset   <= 1'b0;
            r_rst_core    <= 1'b1;
            r_rst_dsp     <= 1'b1;
            r_rst_video   <= 1'b1;
            r_sys_ready   <= 1'b0;
            r_loss_cnt    <= '0;
            r_timeout_cnt <= '0;
        end else if (w_released && !w_lock_s) begin
            // Simultaneous re-assertion of all resets; only a loss from the
            // fully running state is counted.
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= LD_TIMEOUT;
            r_rst_core  <= 1'b1;
            r_rst_dsp   <= 1'b1;
            r_rst_video <= 1'b1;
            r_sys_ready <= 1'b0;
            if ((r_state == S_RUN) && (r_loss_cnt != CNT_SAT)) begin
                r_loss_cnt <= r_loss_cnt + CNT_W'(1);
            end
        end else begin
            case (r_state)
                S_PLL_RST: begin
                    if (w_cnt_zero) begin
                        r_state     <= S_WAIT_LOCK;
                        r_cnt       <= LD_TIMEOUT;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - TW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock seen in the expiry cycle wins over the timeout.
                    if (w_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= LD_STABLE;
                    end else if (w_cnt_zero) begin
                        r_state     <= S_PLL_RST;
                        r_cnt       <= LD_PLL;
                        r_pll_reset <= 1'b1;
                        if (r_timeout_cnt != CNT_SAT) begin
                            r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt - TW'(1);
                    end
                end
                S_STABLE: begin
                    // Any dropout restarts qualification with a fresh timeout.
                    if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= LD_TIMEOUT;
                    end else if (w_cnt_zero) begin
                        r_state    <= S_REL_CORE;
                        r_cnt      <= LD_STAGGER;
                        r_rst_core <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - TW'(1);
                    end
                end
                S_REL_CORE: begin
                    if (w_cnt_zero) begin
                        r_state   <= S_REL_DSP;
                        r_cnt     <= LD_STAGGER;
                        r_rst_dsp <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - TW'(1);
                    end
                end
                S_REL_DSP: begin
                    if (w_cnt_zero) begin
                        r_state     <= S_REL_VIDEO;
                        r_cnt       <= LD_STAGGER;
                        r_rst_video <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - TW'(1);
                    end
                end
                S_REL_VIDEO: begin
                    if (w_cnt_zero) begin
                        r_state     <= S_RUN;
                        r_cnt       <= '0;
                        r_sys_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - TW'(1);
                    end
                end
                S_RUN: begin
                    r_cnt <= '0;
                end
                default: begin
                    // Unused code: fall back to a safe, fully reset state.
                    r_state     <= S_WAIT_LOCK;
                    r_cnt       <= LD_TIMEOUT;
                    r_pll_reset <= 1'b0;
                    r_rst_core  <= 1'b1;
                    r_rst_dsp   <= 1'b1;
                    r_rst_video <= 1'b1;
                    r_sys_ready <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset_o     = r_pll_reset;
    assign rst_core_o      = r_rst_core;
    assign rst_dsp_o       = r_rst_dsp;
    assign rst_video_o     = r_rst_video;
    assign sys_ready_o     = r_sys_ready;
    assign lock_loss_cnt_o = r_loss_cnt;
    assign timeout_cnt_o   = r_timeout_cnt;
    assign state_o         = r_state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq with shortened timing parameters and 2-bit event counters.
// A timestamp-style reference model is compared against every output on every cycle,
// alongside a vector table and hand-written corner-case sequences.

module tb_pll_reset_seq;

    localparam int SS      = 2;
    localparam int PRC     = 3;
    localparam int LS      = 8;
    localparam int LT      = 40;
    localparam int ST      = 4;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_lock_i;
    logic          pll_reset_o;
    logic          rst_core_o;
    logic          rst_dsp_o;
    logic          rst_video_o;
    logic          sys_ready_o;
    logic [CW-1:0] lock_loss_cnt_o;
    logic [CW-1:0] timeout_cnt_o;
    logic [2:0]    state_o;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .SYNC_STAGES   (SS),
        .PLL_RST_CYCLES(PRC),
        .LOCK_STABLE   (LS),
        .LOCK_TIMEOUT  (LT),
        .STAGGER       (ST),
        .CNT_W         (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_lock_i     (pll_lock_i),
        .pll_reset_o    (pll_reset_o),
        .rst_core_o     (rst_core_o),
        .rst_dsp_o      (rst_dsp_o),
        .rst_video_o    (rst_video_o),
        .sys_ready_o    (sys_ready_o),
        .lock_loss_cnt_o(lock_loss_cnt_o),
        .timeout_cnt_o  (timeout_cnt_o),
        .state_o        (state_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Phases: pulsing the PLL reset, waiting for lock, or in the locked sequence.
    // In the locked sequence everything is a threshold on the age since entry.
    typedef enum int {M_PULSE, M_WAIT, M_SEQ} mphase_t;
    mphase_t m_phase = M_WAIT;
    int      m_age   = 0;
    int      m_loss  = 0;
    int      m_tmo   = 0;
    logic    m_hist[$];

    // Output vector: {pll, core, dsp, video, ready, loss[1:0], tmo[1:0], state[2:0]}
    function automatic logic [11:0] mk(bit p, bit c, bit d, bit v, bit rdy, int ls, int tm, int st);
        return {p, c, d, v, rdy, 2'(ls), 2'(tm), 3'(st)};
    endfunction

    task automatic model_step(input logic r, input logic l);
        logic ls;
        if (r) begin
            m_phase = M_WAIT;
            m_age   = 0;
            m_loss  = 0;
            m_tmo   = 0;
            m_hist.delete();
            for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
            return;
        end
        ls = m_hist.pop_front();
        m_hist.push_back(l);
        case (m_phase)
            M_PULSE: begin
                if (m_age == PRC - 1) begin m_phase = M_WAIT; m_age = 0; end
                else m_age++;
            end
            M_WAIT: begin
                if (ls) begin
                    m_phase = M_SEQ; m_age = 0;
                end else if (m_age == LT - 1) begin
                    m_tmo   = (m_tmo < CNT_MAX) ? m_tmo + 1 : m_tmo;
                    m_phase = M_PULSE; m_age = 0;
                end else m_age++;
            end
            default: begin
                if (!ls) begin
                    if (m_age >= LS + 3 * ST) m_loss = (m_loss < CNT_MAX) ? m_loss + 1 : m_loss;
                    m_phase = M_WAIT; m_age = 0;
                end else m_age++;
            end
        endcase
    endtask

    function automatic logic [11:0] model_out();
        bit seq;
        int st;
        seq = (m_phase == M_SEQ);
        if (m_phase == M_PULSE)     st = 0;
        else if (m_phase == M_WAIT) st = 1;
        else st = 2 + int'(m_age >= LS) + int'(m_age >= LS + ST) + int'(m_age >= LS + 2 * ST) + int'(m_age >= LS + 3 * ST);
        return mk(m_phase == M_PULSE, !(seq && m_age >= LS), !(seq && m_age >= LS + ST),
                  !(seq && m_age >= LS + 2 * ST), seq && m_age >= LS + 3 * ST, m_loss, m_tmo, st);
    endfunction

    function automatic logic [11:0] dut_vec();
        return {pll_reset_o, rst_core_o, rst_dsp_o, rst_video_o, sys_ready_o,
                lock_loss_cnt_o, timeout_cnt_o, state_o};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_vec(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %03h expected %03h ({pll,core,dsp,video,rdy,loss,tmo,state})", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive on the falling edge, update the model on the rising edge,
    // sample on the next falling edge.
    task automatic tick(input logic r, input logic l);
        rst        = r;
        pll_lock_i = l;
        @(posedge clk);
        model_step(r, l);
        @(negedge clk);
        check_vec("model", dut_vec(), model_out());
    endtask

    typedef struct {
        logic        r;
        logic        l;
        int          n;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst        = 1'b1;
        pll_lock_i = 1'b0;

        // Power-up, loss in RUN, relock, then two timeouts with lock held low.
        tbl.push_back('{1'b1, 1'b0, 5,  mk(0, 1, 1, 1, 0, 0, 0, 1)});
        tbl.push_back('{1'b0, 1'b0, 5,  mk(0, 1, 1, 1, 0, 0, 0, 1)});
        tbl.push_back('{1'b0, 1'b1, 2,  mk(0, 1, 1, 1, 0, 0, 0, 1)});
        tbl.push_back('{1'b0, 1'b1, 1,  mk(0, 1, 1, 1, 0, 0, 0, 2)});
        tbl.push_back('{1'b0, 1'b1, 7,  mk(0, 1, 1, 1, 0, 0, 0, 2)});
        tbl.push_back('{1'b0, 1'b1, 1,  mk(0, 0, 1, 1, 0, 0, 0, 3)});
        tbl.push_back('{1'b0, 1'b1, 3,  mk(0, 0, 1, 1, 0, 0, 0, 3)});
        tbl.push_back('{1'b0, 1'b1, 1,  mk(0, 0, 0, 1, 0, 0, 0, 4)});
        tbl.push_back('{1'b0, 1'b1, 4,  mk(0, 0, 0, 0, 0, 0, 0, 5)});
        tbl.push_back('{1'b0, 1'b1, 4,  mk(0, 0, 0, 0, 1, 0, 0, 6)});
        tbl.push_back('{1'b0, 1'b1, 10, mk(0, 0, 0, 0, 1, 0, 0, 6)});
        tbl.push_back('{1'b0, 1'b0, 2,  mk(0, 0, 0, 0, 1, 0, 0, 6)});
        tbl.push_back('{1'b0, 1'b0, 1,  mk(0, 1, 1, 1, 0, 1, 0, 1)});
        tbl.push_back('{1'b0, 1'b1, 3,  mk(0, 1, 1, 1, 0, 1, 0, 2)});
        tbl.push_back('{1'b0, 1'b1, 8,  mk(0, 0, 1, 1, 0, 1, 0, 3)});
        tbl.push_back('{1'b0, 1'b1, 12, mk(0, 0, 0, 0, 1, 1, 0, 6)});
        tbl.push_back('{1'b0, 1'b0, 3,  mk(0, 1, 1, 1, 0, 2, 0, 1)});
        tbl.push_back('{1'b0, 1'b0, 39, mk(0, 1, 1, 1, 0, 2, 0, 1)});
        tbl.push_back('{1'b0, 1'b0, 1,  mk(1, 1, 1, 1, 0, 2, 1, 0)});
        tbl.push_back('{1'b0, 1'b0, 2,  mk(1, 1, 1, 1, 0, 2, 1, 0)});
        tbl.push_back('{1'b0, 1'b0, 1,  mk(0, 1, 1, 1, 0, 2, 1, 1)});
        tbl.push_back('{1'b0, 1'b0, 39, mk(0, 1, 1, 1, 0, 2, 1, 1)});
        tbl.push_back('{1'b0, 1'b0, 1,  mk(1, 1, 1, 1, 0, 2, 2, 0)});
        tbl.push_back('{1'b0, 1'b0, 3,  mk(0, 1, 1, 1, 0, 2, 2, 1)});

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].r, tbl[i].l);
            check_vec($sformatf("table_row%0d", i), dut_vec(), tbl[i].exp);
        end

        // Chatter in STABLE: 5 high, 1 low, then high; window restarts.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        chk("chatter_still_stable", state_o, 2);
        chk("chatter_core_held", rst_core_o, 1);
        tick(1'b0, 1'b1);
        chk("chatter_rel_state", state_o, 3);
        chk("chatter_core_rel", rst_core_o, 0);

        // Loss during REL_DSP: everything back in reset, no loss counted.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        chk("reldsp_state", state_o, 4);
        chk("reldsp_dsp_rel", rst_dsp_o, 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("reldsp_sync_delay", state_o, 4);
        tick(1'b0, 1'b0);
        check_vec("reldsp_loss", dut_vec(), mk(0, 1, 1, 1, 0, 0, 0, 1));

        // Five losses from RUN saturate the 2-bit counter at 3.
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
            chk($sformatf("sat_run%0d", j), state_o, 6);
            for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        end
        chk("sat_loss_cnt", lock_loss_cnt_o, 3);

        // Reset asserted mid-RUN, then the first cycle after release.
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1);
        chk("midrun_ready", sys_ready_o, 1);
        tick(1'b1, 1'b1);
        check_vec("midrun_rst", dut_vec(), mk(0, 1, 1, 1, 0, 0, 0, 1));
        tick(1'b0, 1'b1);
        check_vec("midrun_after", dut_vec(), mk(0, 1, 1, 1, 0, 0, 0, 1));

        // Randomised runs of lock high/low with occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            int   len;
            logic lv;
            len = $urandom_range(60, 1);
            lv  = 1'($urandom_range(1, 0));
            if ($urandom_range(30, 0) == 0) begin
                for (int i = 0; i < int'($urandom_range(3, 1)); i++) tick(1'b1, lv);
            end
            for (int i = 0; i < len; i++) tick(1'b0, lv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
